// File: rtl/fifo_sync_buffer_pkg.sv
// Shared sizing helpers and parameter sanity functions for the synchronous FIFO.
package fifo_sync_buffer_pkg;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit level_ok(input int level, input int depth);
      return (level >= 1) && (level <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_sync_buffer_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_sync_buffer_if
   import fifo_sync_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int PTR_W = ptr_w(FIFO_DEPTH);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [PTR_W-1:0]      count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_sync_mem.sv
// FIFO storage array: one write port and one registered, enabled read port.
module fifo_sync_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   // NOTE: the array has no reset so it maps onto plain RAM/flop arrays; pointers guard stale reads.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO: pointers, occupancy, registered status flags and error pulses
// around the fifo_sync_mem storage.
module fifo_sync_buffer
   import fifo_sync_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic             clk,
   input  logic             rst,
   fifo_sync_buffer_if.slave bus
);

   localparam int PTR_W  = ptr_w(FIFO_DEPTH);
   localparam int ADDR_W = PTR_W - 1;

   if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_bad_depth
      $error("fifo_sync_buffer: FIFO_DEPTH must be a power of two and at least 4");
   end
   if (!level_ok(AF_LEVEL, FIFO_DEPTH)) begin : g_bad_af
      $error("fifo_sync_buffer: AF_LEVEL out of range 1..FIFO_DEPTH-1");
   end
   if (!level_ok(AE_LEVEL, FIFO_DEPTH)) begin : g_bad_ae
      $error("fifo_sync_buffer: AE_LEVEL out of range 1..FIFO_DEPTH-1");
   end

   logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
   logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next, count_next;
   logic             full, empty, almost_full, almost_empty;
   logic             rd_valid, overflow, underflow;
   logic             wr_acc, rd_acc;

   assign wr_acc = bus.wr_en && !full;
   assign rd_acc = bus.rd_en && !empty;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      if (wr_acc) wr_ptr_next = wr_ptr + 1'b1;
      if (rd_acc) rd_ptr_next = rd_ptr + 1'b1;
      // The wrap bit makes the modular difference equal the occupancy, including when full.
      count_next = wr_ptr_next - rd_ptr_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         count        <= count_next;
         full         <= (count_next == PTR_W'(FIFO_DEPTH));
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= PTR_W'(AF_LEVEL));
         almost_empty <= (count_next <= PTR_W'(AE_LEVEL));
         rd_valid     <= rd_acc;
         overflow     <= bus.wr_en && full;
         underflow    <= bus.rd_en && empty;
      end
   end

   fifo_sync_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (bus.wr_data),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (bus.rd_data)
   );

   assign bus.count        = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = almost_full;
   assign bus.almost_empty = almost_empty;
   assign bus.rd_valid     = rd_valid;
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Scoreboard bench for fifo_sync_buffer: a queue-based reference model predicts each cycle's
// outputs, a negedge monitor compares them against the DUT.
module tb_fifo_sync_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   typedef struct {
      logic [DW-1:0] rd_data;
      logic          rd_valid;
      int            count;
      logic          full, empty, af, ae, ovf, udf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] last_rd = '0;

   fifo_sync_buffer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   fifo_sync_buffer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .AF_LEVEL   (AF),
      .AE_LEVEL   (AE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // One clock of stimulus; called just after a rising edge. The model is plain queue arithmetic.
   task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
      exp_t e;
      bit   was_full, was_empty;
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      e.ovf      = we && was_full;
      e.udf      = re && was_empty;
      e.rd_valid = re && !was_empty;
      if (e.rd_valid) last_rd = model_q.pop_front();
      if (we && !was_full) model_q.push_back(wd);
      e.rd_data = last_rd;
      e.count   = model_q.size();
      e.full    = (e.count == DEPTH);
      e.empty   = (e.count == 0);
      e.af      = (e.count >= AF);
      e.ae      = (e.count <= AE);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd_valid",     32'(bus.rd_valid),     32'(e.rd_valid));
         check("rd_data",      32'(bus.rd_data),      32'(e.rd_data));
         check("count",        32'(bus.count),        32'(e.count));
         check("full",         32'(bus.full),         32'(e.full));
         check("empty",        32'(bus.empty),        32'(e.empty));
         check("almost_full",  32'(bus.almost_full),  32'(e.af));
         check("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
         check("overflow",     32'(bus.overflow),     32'(e.ovf));
         check("underflow",    32'(bus.underflow),    32'(e.udf));
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"},        32'(bus.count),        32'd0);
      check({tag, "_empty"},        32'(bus.empty),        32'd1);
      check({tag, "_full"},         32'(bus.full),         32'd0);
      check({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'd1);
      check({tag, "_almost_full"},  32'(bus.almost_full),  32'd0);
      check({tag, "_rd_data"},      32'(bus.rd_data),      32'd0);
      check({tag, "_rd_valid"},     32'(bus.rd_valid),     32'd0);
      check({tag, "_overflow"},     32'(bus.overflow),     32'd0);
      check({tag, "_underflow"},    32'(bus.underflow),    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      bit            fill;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset");

      // Fill with 0x11..0x88, then overflow attempt with 0x99.
      for (int i = 1; i <= 8; i++) begin
         d = DW'(i * 8'h11);
         cycle(1'b1, d, 1'b0);
      end
      cycle(1'b1, 8'h99, 1'b0);

      // Drain in order, then underflow attempt.
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Hold occupancy at 3 with simultaneous traffic across pointer wraps.
      for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), 1'b1);

      // Simultaneous at full (read only) and at empty (write only).
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
      cycle(1'b1, 8'hEE, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h3C, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);

      // Randomized traffic alternating fill-biased and drain-biased phases.
      for (int i = 0; i < 400; i++) begin
         fill = ((i / 40) % 2) == 0;
         cycle($urandom_range(0, 99) < (fill ? 75 : 25), DW'($urandom),
               $urandom_range(0, 99) < (fill ? 25 : 75));
      end
      while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);

      // Mid-operation reset at occupancy 5, asserted between clock edges.
      for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      model_q.delete();
      last_rd = '0;
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 8'hA5, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      repeat (2) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
